// File: rtl/alu_share_arbiter_if.sv
// Request and response bundle shared between the ALU arbiter and its requesters/consumer.
// master = requester/consumer side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_rs1;
  logic [NUM_REQ*32-1:0] req_rs2;
  logic [NUM_REQ*5-1:0]  req_ctrl;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_flag;

  modport master (
    output req_valid, req_rs1, req_rs2, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU among NUM_REQ requesters, result in a one-entry buffer.
// Latency: one cycle from request acceptance to rsp_valid; one op per cycle while rsp_ready=1.
// Backpressure: buffer FULL with rsp_ready=0 deasserts every req_ready and freezes buffer and pointer.
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus,
  output logic [31:0]         alu_rs1_data,
  output logic [31:0]         alu_rs2_data,
  output logic [4:0]          a_ctrl,
  input  logic [31:0]         alu_out,
  input  logic                zero_flag
);

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     win_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] hi_req;
  logic               found;
  logic               can_accept;
  logic               xfer;

  logic               rsp_valid_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [31:0]        rsp_data_q;
  logic               rsp_flag_q;

  assign can_accept = !rsp_valid_q || bus.rsp_ready;

  // Requests at or above the pointer get first pick; the rest cover the wrap-around.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (IDW'(i) >= rr_ptr);
    end
  end

  assign hi_req = bus.req_valid & hi_mask;

  always_comb begin
    found = 1'b0;
    win   = '0;
    if (can_accept && !rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && hi_req[i]) begin
          found = 1'b1;
          win   = IDW'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && bus.req_valid[i]) begin
          found = 1'b1;
          win   = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    grant        = '0;
    alu_rs1_data = '0;
    alu_rs2_data = '0;
    a_ctrl       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && (win == IDW'(i))) begin
        grant[i]     = 1'b1;
        alu_rs1_data = bus.req_rs1[i*32 +: 32];
        alu_rs2_data = bus.req_rs2[i*32 +: 32];
        a_ctrl       = bus.req_ctrl[i*5 +: 5];
      end
    end
  end

  assign xfer    = found;
  assign win_nxt = (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);

  // A push takes priority over a pop, so a same-cycle pop+push simply overwrites the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= 1'b0;
      rr_ptr      <= '0;
    end else if (xfer) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= win;
      rsp_data_q  <= alu_out;
      rsp_flag_q  <= zero_flag;
      rr_ptr      <= win_nxt;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flag  = rsp_flag_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized checks of alu_share_arbiter against a transaction-level reference model.
module tb_alu_share_arbiter;
  localparam int N   = 2;
  localparam int IDW = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_rs1_data;
  logic [31:0] alu_rs2_data;
  logic [4:0]  a_ctrl;
  logic [31:0] alu_out;
  logic        zero_flag;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NUM_REQ(N), .IDW(IDW)) bus();

  alu_share_arbiter #(.NUM_REQ(N), .IDW(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .alu_rs1_data (alu_rs1_data),
    .alu_rs2_data (alu_rs2_data),
    .a_ctrl       (a_ctrl),
    .alu_out      (alu_out),
    .zero_flag    (zero_flag)
  );

  // Behavioural ALU: returns {flag, data}; branch codes give data 0 and a compare flag.
  function automatic logic [32:0] alu_fn(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        f;
    r = '0;
    f = 1'b0;
    case (c)
      5'h00: r = a + b;
      5'h01: r = a - b;
      5'h02: r = a & b;
      5'h03: r = a | b;
      5'h04: r = a ^ b;
      5'h05: r = a << b[4:0];
      5'h0B: f = (a == b);
      5'h0C: f = (a != b);
      5'h0D: f = ($signed(a) < $signed(b));
      5'h0E: f = ($signed(a) >= $signed(b));
      5'h0F: f = (a < b);
      5'h10: f = (a >= b);
      default: r = '0;
    endcase
    if (c < 5'h0B || c > 5'h10) f = (r == 32'h0);
    return {f, r};
  endfunction

  assign {zero_flag, alu_out} = alu_fn(a_ctrl, alu_rs1_data, alu_rs2_data);

  // Requester-side state and reference model of the response buffer.
  bit          v   [N];
  logic [31:0] rs1 [N];
  logic [31:0] rs2 [N];
  logic [4:0]  ctl [N];

  int          checks   = 0;
  int          failures = 0;
  bit          m_valid;
  logic [31:0] m_data;
  logic        m_flag;
  int          m_id;
  int          m_ptr;

  logic [4:0]  ops [10] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h0B, 5'h0C, 5'h0D, 5'h10};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]        = v[i];
      bus.req_rs1[i*32 +: 32] = rs1[i];
      bus.req_rs2[i*32 +: 32] = rs2[i];
      bus.req_ctrl[i*5 +: 5]  = ctl[i];
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    v[i]   = 1'b1;
    ctl[i] = c;
    rs1[i] = a;
    rs2[i] = b;
  endtask

  // Round-robin rule: scan from the pointer, wrapping, first pending requester wins.
  function automatic int pick();
    if (rst || (m_valid && !bus.rsp_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic tick(input string tag, output int w);
    logic [32:0]  r;
    logic [N-1:0] er;
    drive();
    w  = pick();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(er));
    if (w >= 0) begin
      chk({tag, ".alu_rs1"}, alu_rs1_data, rs1[w]);
      chk({tag, ".alu_rs2"}, alu_rs2_data, rs2[w]);
      chk({tag, ".a_ctrl"},  32'(a_ctrl),  32'(ctl[w]));
    end else begin
      chk({tag, ".alu_idle"}, alu_rs1_data | alu_rs2_data | 32'(a_ctrl), 32'h0);
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_flag  = 1'b0;
      m_id    = 0;
      m_ptr   = 0;
    end else if (w >= 0) begin
      r       = alu_fn(ctl[w], rs1[w], rs2[w]);
      m_data  = r[31:0];
      m_flag  = r[32];
      m_id    = w;
      m_valid = 1'b1;
      m_ptr   = (w + 1) % N;
      v[w]    = 1'b0;
    end else if (bus.rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(m_valid));
    chk({tag, ".rsp_data"},  bus.rsp_data,       m_data);
    chk({tag, ".rsp_flag"},  32'(bus.rsp_flag),  32'(m_flag));
    chk({tag, ".rsp_id"},    32'(bus.rsp_id),    32'(m_id));
  endtask

  initial begin
    int w;
    int prev_id;
    rst           = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      v[i]   = 1'b0;
      rs1[i] = '0;
      rs2[i] = '0;
      ctl[i] = '0;
    end
    m_valid = 1'b0;
    m_data  = '0;
    m_flag  = 1'b0;
    m_id    = 0;
    m_ptr   = 0;
    drive();
    @(posedge clk);
    #1;

    // Reset state
    tick("reset0", w);
    tick("reset1", w);
    chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset.rsp_data",  bus.rsp_data,       32'h0);
    rst = 1'b0;

    // Single request: add 5+7
    set_req(0, 5'h00, 32'd5, 32'd7);
    tick("single", w);
    chk("single.data",  bus.rsp_data,       32'd12);
    chk("single.id",    32'(bus.rsp_id),    32'd0);
    chk("single.valid", 32'(bus.rsp_valid), 32'd1);
    tick("drain", w);
    chk("drain.valid",  32'(bus.rsp_valid), 32'd0);
    chk("drain.hold",   bus.rsp_data,       32'd12);

    // Contention after reset: sub 9-3 vs beq 4,4
    rst = 1'b1;
    tick("rst2", w);
    rst = 1'b0;
    set_req(0, 5'h01, 32'd9, 32'd3);
    set_req(1, 5'h0B, 32'd4, 32'd4);
    tick("cont0", w);
    chk("cont0.data", bus.rsp_data,    32'd6);
    chk("cont0.id",   32'(bus.rsp_id), 32'd0);
    tick("cont1", w);
    chk("cont1.flag", 32'(bus.rsp_flag), 32'd1);
    chk("cont1.data", bus.rsp_data,      32'd0);
    chk("cont1.id",   32'(bus.rsp_id),   32'd1);

    // Round-robin fairness over 6 transfers
    set_req(0, 5'h00, 32'd100, 32'd1);
    set_req(1, 5'h00, 32'd200, 32'd2);
    prev_id = -1;
    for (int k = 0; k < 6; k++) begin
      tick("rr", w);
      chk("rr.id", 32'(bus.rsp_id), 32'(k % 2));
      chk("rr.no_repeat", 32'(int'(bus.rsp_id) == prev_id), 32'd0);
      prev_id = int'(bus.rsp_id);
      if (k < 4) set_req(k % 2, 5'h00, 32'(k), 32'd10);
    end

    // Backpressure: FULL with 12, req1 pending
    set_req(0, 5'h00, 32'd5, 32'd7);
    tick("bp_fill", w);
    chk("bp_fill.data", bus.rsp_data, 32'd12);
    bus.rsp_ready = 1'b0;
    set_req(1, 5'h01, 32'd20, 32'd5);
    for (int k = 0; k < 3; k++) begin
      tick("bp_stall", w);
      chk("bp_stall.req_ready", 32'(bus.req_ready), 32'h0);
      chk("bp_stall.data",      bus.rsp_data,       32'd12);
    end
    bus.rsp_ready = 1'b1;
    tick("bp_release", w);
    chk("bp_release.data", bus.rsp_data,    32'd15);
    chk("bp_release.id",   32'(bus.rsp_id), 32'd1);

    // Back-to-back stream from req0
    for (int k = 1; k <= 3; k++) begin
      set_req(0, 5'h00, 32'(k), 32'(k));
      tick("b2b", w);
      chk("b2b.data",  bus.rsp_data,       32'(2 * k));
      chk("b2b.valid", 32'(bus.rsp_valid), 32'd1);
    end

    // Reset while FULL (6) with req1 pending; afterwards req0 must win first
    bus.rsp_ready = 1'b0;
    set_req(1, 5'h01, 32'd8, 32'd1);
    rst = 1'b1;
    tick("rst_mid", w);
    chk("rst_mid.valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid.data",  bus.rsp_data,       32'd0);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(0, 5'h00, 32'd10, 32'd1);
    tick("post_rst0", w);
    chk("post_rst0.id",   32'(bus.rsp_id), 32'd0);
    chk("post_rst0.data", bus.rsp_data,    32'd11);
    tick("post_rst1", w);
    chk("post_rst1.id",   32'(bus.rsp_id), 32'd1);
    chk("post_rst1.data", bus.rsp_data,    32'd7);

    // Randomized traffic, backpressure and occasional reset
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(1, 0) == 1) begin
          set_req(i, ops[$urandom_range(9, 0)],
                  ($urandom_range(1, 0) == 1) ? $urandom : 32'($urandom_range(3, 0)),
                  ($urandom_range(1, 0) == 1) ? $urandom : 32'($urandom_range(3, 0)));
        end
      end
      bus.rsp_ready = ($urandom_range(9, 0) < 7);
      rst           = ($urandom_range(49, 0) == 0);
      tick("rand", w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
